// File: rtl/patternbuf_pkg.sv
// patternbuf_pkg
//   Shared sizing constants, the controller state type and the play_last
//   saturation helper for the patternbuf sequencer.
package patternbuf_pkg;

  localparam int BUF_WIDTH = 8;
  localparam int BUF_SIZE  = 32;
  localparam int PTR_W     = $clog2(BUF_SIZE);
  localparam int SHIFT_LEN = BUF_SIZE * BUF_WIDTH;
  localparam int CNT_W     = $clog2(SHIFT_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PLAY  = 2'd2
  } pb_state_t;

  // Clamp a requested last-field index to the last real field. Widened to
  // 32 bits first so the compare stays meaningful for any buffer size.
  function automatic logic [PTR_W-1:0] sat_last(input logic [PTR_W-1:0] v);
    int unsigned iv;
    iv = 32'(v);
    if (iv >= BUF_SIZE) return PTR_W'(BUF_SIZE - 1);
    return v;
  endfunction

endpackage

// File: rtl/patternbuf_ctrl_cnt.sv
// patternbuf_ctrl_cnt
//   Loadable up-counter with a terminal-count flag.
// Ports:
//   clk, rst   clock, async active-high reset (count -> 0)
//   ld, ld_val synchronous load (wins over inc)
//   inc        count up by one
//   term_val   terminal value compared against the current count
//   count      current value
//   term       count == term_val
module patternbuf_ctrl_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign term = (count == term_val);

endmodule

// File: rtl/patternbuf_ctrl.sv
// patternbuf_ctrl
//   Arbiter/sequencer sharing one patternbuf between a serial host reload,
//   single-field core writes and a valid/ready playback stream.
// Ports:
//   clk, rst                 clock, async active-high reset
//   load_req/load_bit        host reload request and serial data
//   load_pop/load_done       bit consumed this cycle / reload finished pulse
//   wr_valid/wr_addr/wr_data core field write, accepted with wr_ready
//   play_start/play_stop     start at field 0 / abort playback
//   play_last/play_loop      last field and wrap mode, sampled at start
//   play_valid/play_data     stream out, handshaken with play_ready
//   play_done                pulse when a non-looping playback ends
//   busy                     controller not idle
//   ssel/sin/fieldp/field_in/field_write   buffer controls
//   field_byte               buffer read data
//
// state | meaning
// IDLE  | arbitrate: reload > write > play start
// SHIFT | serial reload, one bit per cycle for BUF_SIZE*BUF_WIDTH cycles
// PLAY  | stream fields 0..last; writes steal single cycles
module patternbuf_ctrl
  import patternbuf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_req,
  input  logic                 load_bit,
  output logic                 load_pop,
  output logic                 load_done,
  input  logic                 wr_valid,
  input  logic [PTR_W-1:0]     wr_addr,
  input  logic [BUF_WIDTH-1:0] wr_data,
  output logic                 wr_ready,
  input  logic                 play_start,
  input  logic                 play_stop,
  input  logic [PTR_W-1:0]     play_last,
  input  logic                 play_loop,
  output logic                 play_valid,
  output logic [BUF_WIDTH-1:0] play_data,
  input  logic                 play_ready,
  output logic                 play_done,
  output logic                 busy,
  output logic                 ssel,
  output logic                 sin,
  output logic [PTR_W-1:0]     fieldp,
  output logic [BUF_WIDTH-1:0] field_in,
  output logic                 field_write,
  input  logic [BUF_WIDTH-1:0] field_byte
);

  pb_state_t        state;
  logic [PTR_W-1:0] last_q;
  logic             loop_q;
  logic             load_pend;
  logic             shift_fin;

  logic [CNT_W-1:0] bit_cnt;
  logic             bit_term;
  logic [PTR_W-1:0] ptr;
  logic             ptr_term;

  logic load_take;
  logic wr_take;
  logic play_take;
  logic stop_take;
  logic hs;

  // Per-cycle arbitration decisions; outputs and counters are driven from these.
  always_comb begin
    load_take = 1'b0;
    wr_take   = 1'b0;
    play_take = 1'b0;
    stop_take = 1'b0;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        if (load_req || load_pend) load_take = 1'b1;
        else if (wr_valid)         wr_take   = 1'b1;
        else if (play_start)       play_take = 1'b1;
      end
      PLAY: begin
        if (play_stop)     stop_take = 1'b1;
        else if (wr_valid) wr_take   = 1'b1;
        else               hs        = play_ready;
      end
      default: ;
    endcase
  end

  patternbuf_ctrl_cnt #(.WIDTH(CNT_W)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .ld       (load_take),
    .ld_val   ('0),
    .inc      (state == SHIFT),
    .term_val (CNT_W'(SHIFT_LEN - 1)),
    .count    (bit_cnt),
    .term     (bit_term)
  );

  // Pointer returns to 0 on start, on abort and after the last field
  // (covers both the loop wrap and the clean exit to IDLE).
  patternbuf_ctrl_cnt #(.WIDTH(PTR_W)) u_ptr_cnt (
    .clk      (clk),
    .rst      (rst),
    .ld       (play_take || stop_take || (hs && ptr_term)),
    .ld_val   ('0),
    .inc      (hs && !ptr_term),
    .term_val (last_q),
    .count    (ptr),
    .term     (ptr_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_q    <= '0;
      loop_q    <= 1'b0;
      load_pend <= 1'b0;
      shift_fin <= 1'b0;
      load_done <= 1'b0;
      play_done <= 1'b0;
    end else begin
      // load_done trails the IDLE return by one cycle via shift_fin.
      shift_fin <= 1'b0;
      load_done <= shift_fin;
      play_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_take) begin
            state     <= SHIFT;
            load_pend <= 1'b0;
          end else if (play_take) begin
            state  <= PLAY;
            last_q <= sat_last(play_last);
            loop_q <= play_loop;
          end
        end
        SHIFT: begin
          if (bit_term) begin
            state     <= IDLE;
            shift_fin <= 1'b1;
          end
        end
        PLAY: begin
          if (load_req) load_pend <= 1'b1;
          if (stop_take) begin
            state <= IDLE;
          end else if (hs && ptr_term && !loop_q) begin
            state     <= IDLE;
            play_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign ssel        = (state == SHIFT);
  assign load_pop    = (state == SHIFT);
  assign sin         = (state == SHIFT) && load_bit;
  assign wr_ready    = wr_take;
  assign field_write = wr_take;
  assign field_in    = wr_take ? wr_data : '0;
  assign fieldp      = wr_take ? wr_addr : ((state == PLAY) ? ptr : '0);
  assign play_valid  = (state == PLAY) && !play_stop && !wr_valid;
  assign play_data   = field_byte;

endmodule

// File: tb/tb_patternbuf_ctrl.sv
module tb_patternbuf_ctrl;
  import patternbuf_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 load_req, load_bit, load_pop, load_done;
  logic                 wr_valid, wr_ready;
  logic [PTR_W-1:0]     wr_addr;
  logic [BUF_WIDTH-1:0] wr_data;
  logic                 play_start, play_stop, play_loop, play_valid, play_ready, play_done;
  logic [PTR_W-1:0]     play_last;
  logic [BUF_WIDTH-1:0] play_data;
  logic                 busy, ssel, sin, field_write;
  logic [PTR_W-1:0]     fieldp;
  logic [BUF_WIDTH-1:0] field_in, field_byte;

  always #5 clk = ~clk;

  patternbuf_ctrl dut (
    .clk(clk), .rst(rst),
    .load_req(load_req), .load_bit(load_bit), .load_pop(load_pop), .load_done(load_done),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .play_start(play_start), .play_stop(play_stop), .play_last(play_last), .play_loop(play_loop),
    .play_valid(play_valid), .play_data(play_data), .play_ready(play_ready), .play_done(play_done),
    .busy(busy), .ssel(ssel), .sin(sin), .fieldp(fieldp), .field_in(field_in),
    .field_write(field_write), .field_byte(field_byte)
  );

  // Stand-in buffer: one long shift chain, field i occupies bits [8i+7:8i].
  logic [SHIFT_LEN-1:0] buf_bits;
  always @(posedge clk) begin
    if (ssel) buf_bits <= {buf_bits[SHIFT_LEN-2:0], sin};
    else if (field_write) buf_bits[{fieldp, 3'b000} +: 8] <= field_in;
  end
  assign field_byte = buf_bits[{fieldp, 3'b000} +: 8];

  int n_chk = 0;
  int n_pass = 0;
  int pop_cnt = 0, ld_cnt = 0, pd_cnt = 0, stall_cnt = 0, sh_wr_cnt = 0;

  logic [BUF_WIDTH-1:0] ref_mem [BUF_SIZE];
  bit                   m_act = 0, m_loop = 0, m_shift = 0, m_done_due = 0;
  logic [PTR_W-1:0]     m_ptr = '0, m_last = '0;
  logic [BUF_WIDTH-1:0] played_data [$];
  logic [PTR_W-1:0]     played_idx [$];
  bit                   exp_valid, exp_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference model: transaction-level view of who owns the buffer and
  // which field playback should present next.
  always @(negedge clk) begin
    if (!rst) begin
      exp_wr    = wr_valid && !m_shift && (m_act ? !play_stop : !load_req);
      exp_valid = m_act && !play_stop && !wr_valid;
      check("wr_ready", 32'(wr_ready), 32'(exp_wr));
      check("field_write", 32'(field_write), 32'(exp_wr));
      check("play_valid", 32'(play_valid), 32'(exp_valid));
      check("play_done", 32'(play_done), 32'(m_done_due));
      check("ssel", 32'(ssel), 32'(m_shift));
      check("load_pop", 32'(load_pop), 32'(m_shift));
      check("busy", 32'(busy), 32'(m_act || m_shift));
      check("play_data_follow", 32'(play_data), 32'(field_byte));
      if (m_shift) check("sin", 32'(sin), 32'(load_bit));
      if (exp_wr) begin
        check("fieldp_wr", 32'(fieldp), 32'(wr_addr));
        check("field_in", 32'(field_in), 32'(wr_data));
      end else if (m_act) begin
        check("fieldp_play", 32'(fieldp), 32'(m_ptr));
      end else if (!m_shift) begin
        check("fieldp_idle", 32'(fieldp), 0);
      end
      m_done_due = 0;
      if (m_act && !play_valid) stall_cnt++;
      if (m_shift && wr_ready) sh_wr_cnt++;
      if (exp_valid && play_ready) begin
        check("play_field", 32'(play_data), 32'(ref_mem[m_ptr]));
        played_data.push_back(play_data);
        played_idx.push_back(m_ptr);
        if (m_ptr == m_last) begin
          if (m_loop) m_ptr = '0;
          else begin
            m_act = 0;
            m_done_due = 1;
          end
        end else begin
          m_ptr = m_ptr + 1'b1;
        end
      end
      if (m_act && play_stop) m_act = 0;
      if (exp_wr) ref_mem[wr_addr] = wr_data;
      if (load_pop) pop_cnt++;
      if (load_done) ld_cnt++;
      if (play_done) pd_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the last shift cycle (or right after reset if aborted).
  task automatic do_load(input logic [7:0] pat, input int abort_at);
    load_req = 1;
    step();
    load_req = 0;
    m_shift = 1;
    for (int k = 0; k < SHIFT_LEN; k++) begin
      if (k == abort_at) begin
        rst = 1;
        m_shift = 0;
        #1;
        return;
      end
      load_bit = pat[3'(7 - (k % 8))];
      step();
    end
    m_shift = 0;
    load_bit = 0;
    foreach (ref_mem[i]) ref_mem[i] = pat;
  endtask

  task automatic play_begin(input logic [PTR_W-1:0] last, input logic loop);
    played_data.delete();
    played_idx.delete();
    play_last = last;
    play_loop = loop;
    play_start = 1;
    step();
    play_start = 0;
    m_act = 1;
    m_ptr = '0;
    m_last = last;
    m_loop = loop;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (m_act && n < budget) begin
      step();
      n++;
    end
    check("play_timeout", 32'(m_act), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ssel"}, 32'(ssel), 0);
    check({tag, "_load_pop"}, 32'(load_pop), 0);
    check({tag, "_sin"}, 32'(sin), 0);
    check({tag, "_load_done"}, 32'(load_done), 0);
    check({tag, "_wr_ready"}, 32'(wr_ready), 0);
    check({tag, "_play_valid"}, 32'(play_valid), 0);
    check({tag, "_play_done"}, 32'(play_done), 0);
    check({tag, "_field_write"}, 32'(field_write), 0);
    check({tag, "_fieldp"}, 32'(fieldp), 0);
    check({tag, "_field_in"}, 32'(field_in), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, base, seq;
    rst = 1;
    load_req = 0; load_bit = 0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    play_start = 0; play_stop = 0; play_last = '0; play_loop = 0; play_ready = 0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    #1;
    step();
    step();
    check_zero_outputs("reset");
    rst = 0;
    step();

    // Full reload with 0xA5 in every field, then play all 32.
    pop_cnt = 0;
    ld_cnt = 0;
    do_load(8'hA5, -1);
    check("load_pop_cycles", 32'(pop_cnt), 256);
    check("load_done_early", 32'(load_done), 0);
    step();
    check("load_done_pulse", 32'(load_done), 1);
    step();
    check("load_done_count", 32'(ld_cnt), 1);
    check("load_done_low", 32'(load_done), 0);

    play_ready = 1;
    base = pd_cnt;
    play_begin(5'd31, 0);
    wait_idle(100);
    step();
    check("reload_play_len", 32'(played_data.size()), 32);
    bad = 0;
    foreach (played_data[i]) if (played_data[i] !== 8'hA5) bad++;
    check("reload_play_a5", 32'(bad), 0);
    check("reload_play_done", 32'(pd_cnt - base), 1);

    // Single write in IDLE, then play fields 0..7.
    wr_addr = 5'd7; wr_data = 8'h3C; wr_valid = 1;
    #2;
    check("idle_wr_ready", 32'(wr_ready), 1);
    check("idle_wr_fieldp", 32'(fieldp), 7);
    step();
    wr_valid = 0;
    play_begin(5'd7, 0);
    wait_idle(50);
    step();
    check("write_play_len", 32'(played_data.size()), 8);
    check("write_play_f7", 32'(played_data[7]), 32'h3C);
    check("write_play_f6", 32'(played_data[6]), 32'hA5);

    // Write to field 1 while the pointer sits at 2.
    base = pd_cnt;
    play_begin(5'd3, 0);
    stall_cnt = 0;
    begin
      int n;
      n = 0;
      while (!(m_act && m_ptr == 5'd2) && n < 20) begin
        step();
        n++;
      end
    end
    check("reach_ptr2", 32'(m_ptr), 2);
    wr_addr = 5'd1; wr_data = 8'h5A; wr_valid = 1;
    #2;
    check("play_wr_ready", 32'(wr_ready), 1);
    check("play_wr_valid_low", 32'(play_valid), 0);
    step();
    wr_valid = 0;
    #2;
    check("play_ptr_held", 32'(fieldp), 2);
    check("play_resume_valid", 32'(play_valid), 1);
    wait_idle(20);
    step();
    seq = 0;
    foreach (played_idx[i]) seq = (seq << 8) | 32'(played_idx[i]);
    check("play_wr_order", 32'(seq), 32'h00010203);
    check("play_wr_stall", 32'(stall_cnt), 1);
    check("play_wr_done", 32'(pd_cnt - base), 1);

    // Looping 0,1 with play_ready toggling, then abort.
    base = pd_cnt;
    play_begin(5'd1, 1);
    for (int i = 0; i < 12; i++) begin
      play_ready = (i % 2 == 0);
      step();
    end
    check("loop_len", 32'(played_data.size()), 6);
    seq = 0;
    for (int i = 0; i < 4; i++) seq = (seq << 8) | 32'(played_idx[i]);
    check("loop_order", 32'(seq), 32'h00010001);
    seq = 0;
    for (int i = 0; i < 4; i++) seq = (seq << 8) | 32'(played_data[i]);
    check("loop_data", 32'(seq), 32'hA55AA55A);
    play_ready = 1;
    play_stop = 1;
    #2;
    check("stop_valid_low", 32'(play_valid), 0);
    step();
    play_stop = 0;
    check("stop_idle", 32'(busy), 0);
    for (int i = 0; i < 4; i++) step();
    check("stop_no_done", 32'(pd_cnt - base), 0);

    // Reload, write and start requested together.
    sh_wr_cnt = 0;
    wr_addr = 5'd9; wr_data = 8'h77; wr_valid = 1;
    play_last = 5'd9; play_loop = 0; play_start = 1;
    played_data.delete();
    played_idx.delete();
    do_load(8'hC3, -1);
    check("prio_no_wr_in_shift", 32'(sh_wr_cnt), 0);
    #2;
    check("prio_wr_after_load", 32'(wr_ready), 1);
    check("prio_idle_after_load", 32'(busy), 0);
    step();
    wr_valid = 0;
    #2;
    check("prio_load_done", 32'(load_done), 1);
    check("prio_start_pending", 32'(busy), 0);
    step();
    play_start = 0;
    m_act = 1; m_ptr = '0; m_last = 5'd9; m_loop = 0;
    check("prio_playing", 32'(busy), 1);
    wait_idle(50);
    step();
    check("prio_play_len", 32'(played_data.size()), 10);
    check("prio_f9", 32'(played_data[9]), 32'h77);
    check("prio_f0", 32'(played_data[0]), 32'hC3);

    // Reset while 100 bits into a reload.
    base = ld_cnt;
    do_load(8'hFF, 100);
    check_zero_outputs("midshift");
    load_bit = 0;
    step();
    step();
    rst = 0;
    for (int i = 0; i < 300; i++) step();
    check("midshift_no_done", 32'(ld_cnt - base), 0);
    check("midshift_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/patternbuf_ctrl.md
# patternbuf_ctrl

Sequencer and arbiter in front of `patternbuf`. It shares the buffer between three requesters: a full serial reload from the host, single-field writes from the core, and a playback engine that streams fields out with a valid/ready handshake. It drives the buffer's `ssel`/`sin`/`fieldp`/`field_in`/`field_write` inputs and reads back `field_byte`.

## Interface
- `BUF_WIDTH`, 8, bits per field
- `BUF_SIZE`, 32, number of fields; `PTR_W` = clog2(`BUF_SIZE`) = 5
- `clk`  in  1  single clock, rising edge; the buffer runs on the same clock
- `rst`  in  1  asynchronous, active-high reset
- `load_req`  in  1  level; requests a full serial reload of `BUF_SIZE*BUF_WIDTH` bits
- `load_bit`  in  1  serial data, sampled on every cycle in which `load_pop`=1
- `load_pop`  out  1  high in each cycle that consumes `load_bit`
- `load_done`  out  1  one-cycle pulse after the last bit is shifted
- `wr_valid`  in  1  core field-write request
- `wr_addr`  in  PTR_W  target field
- `wr_data`  in  BUF_WIDTH  write data
- `wr_ready`  out  1  write accepted when `wr_valid`&`wr_ready`
- `play_start`  in  1  pulse; starts playback at field 0
- `play_stop`  in  1  pulse; aborts playback
- `play_last`  in  PTR_W  index of the last field played; sampled at start
- `play_loop`  in  1  wrap to field 0 after `play_last`; sampled at start
- `play_valid`  out  1  `play_data` is valid
- `play_data`  out  BUF_WIDTH  current field, equal to `field_byte`
- `play_ready`  in  1  consumer accepts
- `play_done`  out  1  one-cycle pulse when a non-loop playback completes
- `busy`  out  1  state ≠ IDLE
- `ssel`, `sin`, `fieldp[PTR_W]`, `field_in[BUF_WIDTH]`, `field_write`  out  drive the buffer
- `field_byte`  in  BUF_WIDTH  from the buffer

## Operation
- States: IDLE, SHIFT, PLAY.
- **IDLE priority:** `load_req` > `wr_valid` > `play_start`.
  - `load_req` goes to SHIFT.
  - A write is done in place: `wr_ready`=1 and `field_write`=1, with `fieldp`=`wr_addr` and `field_in`=`wr_data`.
  - `play_start` goes to PLAY, sets ptr=0 and latches `play_last` and `play_loop`.
- **SHIFT:**
  - `ssel`=1, `load_pop`=1, `sin`=`load_bit` for exactly `BUF_SIZE*BUF_WIDTH` (256) consecutive cycles, counted by an 8-bit counter.
  - `wr_ready`=0 throughout.
  - On the final count, return to IDLE and pulse `load_done` in the next cycle.
  - Shift is atomic: `load_req` deassertion, `play_start` and `wr_valid` are ignored.
- **PLAY:**
  - `fieldp`=ptr, `play_valid`=1, `play_data`=`field_byte`.
  - On a handshake: if ptr=`play_last`, go to ptr=0 when looping, else go to IDLE and pulse `play_done`. Otherwise ptr+1.
- **Write during PLAY:**
  - `wr_valid` takes precedence for one cycle: `wr_ready`=1, `field_write`=1, `fieldp`=`wr_addr`, `play_valid`=0, ptr held.
  - Back-to-back writes starve playback; this is allowed.
- **`play_stop`:** goes to IDLE next cycle; no `play_done`; highest priority within PLAY, above `wr_valid`.
- **`load_req` during PLAY:** held pending, taken once in IDLE.
- **`play_last` ≥ `BUF_SIZE`:** cannot occur for `PTR_W`=5; for other sizes it saturates to `BUF_SIZE`-1 at latch.
- **`play_start` while in PLAY:** ignored.
- **Idle outputs:** `ssel`=0 outside SHIFT; `field_write`=0 unless a write is accepted; `fieldp`=0 in IDLE with no write.

## Timing
- **Reset values:** state IDLE; all outputs 0; counters and ptr 0; `play_data` follows `field_byte`.
- **Reset mid-SHIFT:** the buffer holds a partial shift and its contents are undefined; a new `load_req` is required.
- **Write latency:** field updated at the edge ending the accept cycle. Its data is visible on `field_byte` in the next cycle if `fieldp` points to it.
- **Playback latency:** `play_valid` rises the cycle after `play_start`. Sustained rate is one field per cycle while `play_ready`=1.
- **Load latency:** SHIFT entered the cycle after `load_req` is seen in IDLE. `load_done` is 257 cycles after entry.
- **Combinational paths:**
  - `wr_ready` and `play_valid` depend combinationally on `wr_valid`, `play_stop` and state.
  - Requesters must not make `wr_valid` depend on `wr_ready`.

## Structure
- Shared `patternbuf_pkg`: `BUF_WIDTH`, `BUF_SIZE`, `PTR_W`, and the state enum `pb_state_t` {IDLE, SHIFT, PLAY}.
- One sub-module: `patternbuf_ctrl_cnt`, a loadable up-counter with a terminal flag. It is instanced for the 8-bit shift count and for the play pointer.
- `patternbuf_ctrl` holds the FSM and the output muxing.

## Test plan
- **Reload:** reset, then `load_req` with 256 bits of 0xA5 per field. `load_pop` is high for 256 cycles and `load_done` pulses once; a subsequent play of `play_last`=31 yields 32×0xA5.
- **Single write:** in IDLE, write `wr_addr`=7, `wr_data`=0x3C (accepted the same cycle); a later play of `play_last`=7 yields 0x3C as its eighth field.
- **Write during PLAY:**
  - Setup: PLAY with `play_ready`=1 and `play_last`=3.
  - Stimulus: at ptr=2, a write to field 1.
  - Required: `play_valid`=0 for one cycle and the ptr holds; the sequence continues 2, 3, then `play_done`.
- **Loop and abort:**
  - Play `play_last`=1 with `play_loop`=1 and `play_ready` toggling: the output is fields 0,1,0,1… with the ptr advancing only on handshakes.
  - `play_stop`: IDLE next cycle, no `play_done`.
- **Priority:**
  - `load_req`, `wr_valid` and `play_start` asserted together in IDLE: SHIFT wins and `wr_ready`=0 for 256 cycles.
  - After `load_done`, the write is accepted before play starts.
- **Reset mid-SHIFT:** assert `rst` at bit 100. All outputs go to 0 immediately, state is IDLE, and `load_done` is never pulsed.
